// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolve unit.
package bru_pkg;

  typedef enum logic [1:0] {
    BRU_BR   = 2'd0,
    BRU_JAL  = 2'd1,
    BRU_JALR = 2'd2
  } bru_kind_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Control part of the S1 payload; wide fields live beside it so XLEN stays a module parameter.
  typedef struct packed {
    logic taken;
    logic illegal;
    logic pred_taken;
  } s1_ctrl_t;

endpackage

// File: rtl/bru_cond.sv
// Combinational B-type condition evaluator: funct3, d1, d2 -> cond, illegal.
module bru_cond #(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] d1,
  input  logic [XLEN-1:0] d2,
  output logic            cond,
  output logic            illegal
);
  import bru_pkg::*;

  // Select the comparison; the two unused encodings flag illegal and never satisfy the condition.
  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  cond = (d1 == d2);
      F3_BNE:  cond = (d1 != d2);
      F3_BLT:  cond = ($signed(d1) < $signed(d2));
      F3_BGE:  cond = ($signed(d1) >= $signed(d2));
      F3_BLTU: cond = (d1 < d2);
      F3_BGEU: cond = (d1 >= d2);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Two-stage branch/jump resolver (BR, JAL, JALR) with valid/ready on both sides.
// S1 holds the resolved condition and target, S2 holds next PC and mispredict.
// Optional statistics counters are built when BRU_STATS_EN is defined.
module branch_resolve_unit #(
  parameter int XLEN    = 32,
  parameter int PC_STEP = 4
`ifdef BRU_STATS_EN
  , parameter int STAT_W = 16
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_kind,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_d1,
  input  logic [XLEN-1:0] in_d2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_pred_taken,
  input  logic [XLEN-1:0] in_pred_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc_new,
  output logic [XLEN-1:0] out_link,
  output logic            out_taken,
  output logic            out_mispredict,
  output logic            out_illegal,
  output logic            out_misalign
`ifdef BRU_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_taken,
  output logic [STAT_W-1:0] stat_mispred
`endif
);
  import bru_pkg::*;

  logic            cond, cond_illegal;
  logic            s1_adv, s2_adv;
  logic [XLEN-1:0] jalr_sum, in_target, in_link;
  s1_ctrl_t        in_ctrl;

  logic            s1_valid_d, s1_valid_q;
  s1_ctrl_t        s1_ctrl_d, s1_ctrl_q;
  logic [XLEN-1:0] s1_target_d, s1_target_q;
  logic [XLEN-1:0] s1_link_d, s1_link_q;
  logic [XLEN-1:0] s1_pred_target_d, s1_pred_target_q;

  logic            s2_valid_d, s2_valid_q;
  logic [XLEN-1:0] s2_pc_new_d, s2_pc_new_q;
  logic [XLEN-1:0] s2_link_d, s2_link_q;
  logic            s2_taken_d, s2_taken_q;
  logic            s2_mispredict_d, s2_mispredict_q;
  logic            s2_illegal_d, s2_illegal_q;
  logic            s2_misalign_d, s2_misalign_q;

  bru_cond #(.XLEN(XLEN)) u_cond (
    .funct3  (in_funct3),
    .d1      (in_d1),
    .d2      (in_d2),
    .cond    (cond),
    .illegal (cond_illegal)
  );

  // A stage moves when its successor has room; flush always frees the input side.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv || flush;

  // Decode the incoming op into taken/illegal and its transfer target.
  always_comb begin
    jalr_sum   = in_d1 + in_imm;
    in_link    = in_pc + XLEN'(PC_STEP);
    in_target  = in_pc + in_imm;
    in_ctrl    = '0;
    in_ctrl.pred_taken = in_pred_taken;
    case (in_kind)
      BRU_BR: begin
        in_ctrl.illegal = cond_illegal;
        in_ctrl.taken   = cond && !cond_illegal;
      end
      BRU_JAL:  in_ctrl.taken = 1'b1;
      BRU_JALR: begin
        in_ctrl.taken = 1'b1;
        in_target     = {jalr_sum[XLEN-1:1], 1'b0};
      end
      default:  in_ctrl.illegal = 1'b1;
    endcase
  end

  // Next-state for both pipeline stages, including stall hold and flush kill.
  always_comb begin
    s1_valid_d       = s1_valid_q;
    s1_ctrl_d        = s1_ctrl_q;
    s1_target_d      = s1_target_q;
    s1_link_d        = s1_link_q;
    s1_pred_target_d = s1_pred_target_q;
    s2_valid_d       = s2_valid_q;
    s2_pc_new_d      = s2_pc_new_q;
    s2_link_d        = s2_link_q;
    s2_taken_d       = s2_taken_q;
    s2_mispredict_d  = s2_mispredict_q;
    s2_illegal_d     = s2_illegal_q;
    s2_misalign_d    = s2_misalign_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_ctrl_d        = in_ctrl;
        s1_target_d      = in_target;
        s1_link_d        = in_link;
        s1_pred_target_d = in_pred_target;
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_taken_d      = s1_ctrl_q.taken;
        s2_illegal_d    = s1_ctrl_q.illegal;
        s2_link_d       = s1_link_q;
        s2_pc_new_d     = s1_ctrl_q.taken ? s1_target_q : s1_link_q;
        s2_mispredict_d = (s1_ctrl_q.taken != s1_ctrl_q.pred_taken) ||
                          (s1_ctrl_q.taken && (s1_target_q != s1_pred_target_q));
        s2_misalign_d   = s1_ctrl_q.taken && s1_target_q[1];
      end
    end

    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q       <= 1'b0;
      s1_ctrl_q        <= '0;
      s1_target_q      <= '0;
      s1_link_q        <= '0;
      s1_pred_target_q <= '0;
      s2_valid_q       <= 1'b0;
      s2_pc_new_q      <= '0;
      s2_link_q        <= '0;
      s2_taken_q       <= 1'b0;
      s2_mispredict_q  <= 1'b0;
      s2_illegal_q     <= 1'b0;
      s2_misalign_q    <= 1'b0;
    end else begin
      s1_valid_q       <= s1_valid_d;
      s1_ctrl_q        <= s1_ctrl_d;
      s1_target_q      <= s1_target_d;
      s1_link_q        <= s1_link_d;
      s1_pred_target_q <= s1_pred_target_d;
      s2_valid_q       <= s2_valid_d;
      s2_pc_new_q      <= s2_pc_new_d;
      s2_link_q        <= s2_link_d;
      s2_taken_q       <= s2_taken_d;
      s2_mispredict_q  <= s2_mispredict_d;
      s2_illegal_q     <= s2_illegal_d;
      s2_misalign_q    <= s2_misalign_d;
    end
  end

  assign out_valid      = s2_valid_q;
  assign out_pc_new     = s2_pc_new_q;
  assign out_link       = s2_link_q;
  assign out_taken      = s2_taken_q;
  assign out_mispredict = s2_mispredict_q;
  assign out_illegal    = s2_illegal_q;
  assign out_misalign   = s2_misalign_q;

`ifdef BRU_STATS_EN
  logic [STAT_W-1:0] stat_taken_d, stat_taken_q;
  logic [STAT_W-1:0] stat_mispred_d, stat_mispred_q;

  // Count results the consumer actually takes; a result leaving during a flush is not counted.
  always_comb begin
    stat_taken_d   = stat_taken_q;
    stat_mispred_d = stat_mispred_q;
    if (s2_valid_q && out_ready && !flush) begin
      if (s2_taken_q && !(&stat_taken_q))
        stat_taken_d = stat_taken_q + STAT_W'(1);
      if (s2_mispredict_q && !(&stat_mispred_q))
        stat_mispred_d = stat_mispred_q + STAT_W'(1);
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_taken_q   <= '0;
      stat_mispred_q <= '0;
    end else begin
      stat_taken_q   <= stat_taken_d;
      stat_mispred_q <= stat_mispred_d;
    end
  end

  assign stat_taken   = stat_taken_q;
  assign stat_mispred = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit.
module tb_branch_resolve_unit;

  typedef struct packed {
    logic [31:0] pc_new;
    logic [31:0] link;
    logic        taken;
    logic        mispredict;
    logic        illegal;
    logic        misalign;
  } exp_t;

  typedef struct packed {
    logic [1:0]  kind;
    logic [2:0]  f3;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptgt;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_kind = '0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_d1 = '0, in_d2 = '0, in_imm = '0, in_pc = '0, in_pred_target = '0;
  logic        in_pred_taken = 1'b0;
  logic        out_valid, out_ready;
  logic [31:0] out_pc_new, out_link;
  logic        out_taken, out_mispredict, out_illegal, out_misalign;
  logic        ready_force = 1'b1, rand_mode = 1'b0, rdy_rnd = 1'b1;
`ifdef BRU_STATS_EN
  logic [15:0] stat_taken, stat_mispred;
  logic [15:0] exp_stat_taken = '0, exp_stat_mispred = '0;
`endif

  assign out_ready = rand_mode ? rdy_rnd : ready_force;

  branch_resolve_unit dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_funct3(in_funct3),
    .in_d1(in_d1), .in_d2(in_d2), .in_imm(in_imm), .in_pc(in_pc),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc_new(out_pc_new), .out_link(out_link),
    .out_taken(out_taken), .out_mispredict(out_mispredict), .out_illegal(out_illegal),
    .out_misalign(out_misalign)
`ifdef BRU_STATS_EN
    , .stat_taken(stat_taken), .stat_mispred(stat_mispred)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input op_t o);
    exp_t e;
    logic cond, ill;
    logic [31:0] tgt;
    cond = 1'b0;
    ill  = 1'b0;
    tgt  = o.pc + o.imm;
    case (o.kind)
      2'd0: case (o.f3)
        3'b000: cond = (o.d1 == o.d2);
        3'b001: cond = (o.d1 != o.d2);
        3'b100: cond = ($signed(o.d1) < $signed(o.d2));
        3'b101: cond = !($signed(o.d1) < $signed(o.d2));
        3'b110: cond = (o.d1 < o.d2);
        3'b111: cond = !(o.d1 < o.d2);
        default: ill = 1'b1;
      endcase
      2'd1: cond = 1'b1;
      2'd2: begin cond = 1'b1; tgt = (o.d1 + o.imm) & 32'hFFFF_FFFE; end
      default: ill = 1'b1;
    endcase
    e.taken      = cond && !ill;
    e.illegal    = ill;
    e.link       = o.pc + 32'd4;
    e.pc_new     = e.taken ? tgt : e.link;
    e.mispredict = (e.taken != o.pt) || (e.taken && tgt != o.ptgt);
    e.misalign   = e.taken && tgt[1];
    return e;
  endfunction

  function automatic op_t cur_op();
    op_t o;
    o.kind = in_kind; o.f3 = in_funct3; o.d1 = in_d1; o.d2 = in_d2;
    o.imm = in_imm; o.pc = in_pc; o.pt = in_pred_taken; o.ptgt = in_pred_target;
    return o;
  endfunction

  // Monitor: push expectations on accept, pop and compare on output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("sb_unexpected_out", 32'd1, 32'd0);
          end else begin
            mon_e = sb.pop_front();
            check("pc_new", out_pc_new, mon_e.pc_new);
            check("link", out_link, mon_e.link);
            check("taken", 32'(out_taken), 32'(mon_e.taken));
            check("mispredict", 32'(out_mispredict), 32'(mon_e.mispredict));
            check("illegal", 32'(out_illegal), 32'(mon_e.illegal));
            check("misalign", 32'(out_misalign), 32'(mon_e.misalign));
`ifdef BRU_STATS_EN
            if (mon_e.taken && exp_stat_taken != 16'hFFFF) exp_stat_taken++;
            if (mon_e.mispredict && exp_stat_mispred != 16'hFFFF) exp_stat_mispred++;
`endif
          end
        end
        if (in_valid && in_ready) sb.push_back(model(cur_op()));
      end
    end
  end

  always begin
    @(posedge clk);
    #1 rdy_rnd = ($urandom_range(0, 3) != 0);
  end

  task automatic drive(input op_t o);
    in_kind = o.kind; in_funct3 = o.f3; in_d1 = o.d1; in_d2 = o.d2;
    in_imm = o.imm; in_pc = o.pc; in_pred_taken = o.pt; in_pred_target = o.ptgt;
  endtask

  task automatic send(input op_t o);
    int n;
    logic acc;
    n = 0;
    acc = 1'b0;
    drive(o);
    in_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check("drain_left", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
`ifdef BRU_STATS_EN
    check("stat_taken", 32'(stat_taken), 32'(exp_stat_taken));
    check("stat_mispred", 32'(stat_mispred), 32'(exp_stat_mispred));
`endif
  endtask

  function automatic op_t mk(input logic [1:0] k, input logic [2:0] f3, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] imm, input logic [31:0] pc,
                             input logic pt, input logic [31:0] ptgt);
    op_t o;
    o.kind = k; o.f3 = f3; o.d1 = d1; o.d2 = d2; o.imm = imm; o.pc = pc; o.pt = pt; o.ptgt = ptgt;
    return o;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'd5;
      3: return 32'hFFFF_FFFF;
      4: return 32'h8000_0000;
      5: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  op_t dir[$];
  op_t st_ops[4];
  op_t o;
  exp_t e0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_pc_new", out_pc_new, 32'd0);
    check("rst_link", out_link, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // BEQ latency: result visible two edges after acceptance
    send(mk(2'd0, 3'b000, 32'd5, 32'd5, 32'h20, 32'h100, 1'b0, 32'h0));
    @(posedge clk);
    #1;
    check("beq_lat_valid", 32'(out_valid), 32'd1);
    check("beq_pc_new", out_pc_new, 32'h120);
    check("beq_taken", 32'(out_taken), 32'd1);
    check("beq_mispredict", 32'(out_mispredict), 32'd1);
    drain();

    // Directed ops back-to-back
    dir.push_back(mk(2'd0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h200, 1'b1, 32'h240));
    dir.push_back(mk(2'd0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h200, 1'b0, 32'h0));
    dir.push_back(mk(2'd2, 3'b000, 32'h1003, 32'd0, 32'd0, 32'h300, 1'b1, 32'h1002));
    dir.push_back(mk(2'd0, 3'b010, 32'd1, 32'd1, 32'h8, 32'h400, 1'b1, 32'h408));
    dir.push_back(mk(2'd0, 3'b011, 32'd1, 32'd2, 32'h8, 32'h400, 1'b0, 32'h0));
    dir.push_back(mk(2'd3, 3'b000, 32'd1, 32'd1, 32'h8, 32'h500, 1'b0, 32'h0));
    dir.push_back(mk(2'd1, 3'b000, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h8, 1'b1, 32'hFFFF_FFF8));
    dir.push_back(mk(2'd0, 3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 32'h10, 32'hFFFF_FFFC, 1'b0, 32'h0));
    dir.push_back(mk(2'd0, 3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h10, 32'hFFFF_FFFC, 1'b1, 32'hC));
    dir.push_back(mk(2'd0, 3'b001, 32'd7, 32'd7, 32'h10, 32'h600, 1'b1, 32'h610));
    dir.push_back(mk(2'd1, 3'b000, 32'd0, 32'd0, 32'h6, 32'h700, 1'b1, 32'h704));
    foreach (dir[i]) send(dir[i]);
    drain();

    // Four ops with out_ready held low for three cycles
    ready_force = 1'b0;
    for (int i = 0; i < 4; i++)
      st_ops[i] = mk(2'd0, 3'b000, 32'(i), 32'(i), 32'h10 * (i + 1), 32'h800 + 32'(8 * i), 1'b0, 32'h0);
    e0 = model(st_ops[0]);
    fork
      begin
        for (int i = 0; i < 4; i++) send(st_ops[i]);
      end
      begin
        @(posedge clk);
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check("stall_in_ready", 32'(in_ready), 32'd0);
          check("stall_out_valid", 32'(out_valid), 32'd1);
          check("stall_pc_new", out_pc_new, e0.pc_new);
        end
        @(posedge clk);
        #1 ready_force = 1'b1;
      end
    join
    drain();

    // Flush with both stages full; an op offered in the flush cycle is dropped
    ready_force = 1'b0;
    send(mk(2'd1, 3'b000, 32'd0, 32'd0, 32'h100, 32'h900, 1'b0, 32'h0));
    send(mk(2'd0, 3'b001, 32'd1, 32'd2, 32'h20, 32'h904, 1'b0, 32'h0));
    flush = 1'b1;
    drive(mk(2'd1, 3'b000, 32'd0, 32'd0, 32'h40, 32'h908, 1'b0, 32'h0));
    in_valid = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    ready_force = 1'b1;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("flush_stays_empty", 32'(out_valid), 32'd0);
    end
    drain();

    // Async reset mid-operation
    ready_force = 1'b0;
    send(mk(2'd1, 3'b000, 32'd0, 32'd0, 32'h10, 32'hA00, 1'b1, 32'hA10));
    send(mk(2'd1, 3'b000, 32'd0, 32'd0, 32'h10, 32'hA04, 1'b1, 32'hA14));
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_pc_new", out_pc_new, 32'd0);
    sb.delete();
`ifdef BRU_STATS_EN
    exp_stat_taken = '0;
    exp_stat_mispred = '0;
`endif
    @(negedge clk);
    #2 rst_n = 1'b1;
    ready_force = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("arst_stays_empty", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Random ops with random backpressure
    rand_mode = 1'b1;
    for (int i = 0; i < 60; i++) begin
      o.kind = ($urandom_range(0, 7) < 5) ? 2'd0 : 2'($urandom_range(1, 3));
      o.f3   = 3'($urandom_range(0, 7));
      o.d1   = pick();
      o.d2   = ($urandom_range(0, 2) == 0) ? o.d1 : pick();
      o.imm  = 32'(($urandom_range(0, 63) - 32) * 2);
      o.pc   = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF0 : 32'h1000 + 32'(4 * $urandom_range(0, 255));
      o.pt   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1)
        o.ptgt = (o.kind == 2'd2) ? ((o.d1 + o.imm) & 32'hFFFF_FFFE) : (o.pc + o.imm);
      else
        o.ptgt = $urandom();
      send(o);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_mode = 1'b0;
    ready_force = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
